// File: rtl/strobe_pacer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : strobe_pacer_pkg
//  Purpose  : Shared types and helpers for the strobe pacer slice.
//  Revision : 1.0  initial release
// ============================================================================
package strobe_pacer_pkg;

   // The pacer has two implicit states, decoded from the spacing counter.
   typedef enum logic {
      PACE_READY   = 1'b0,   // spacing counter is zero, a toggle may fire
      PACE_SPACING = 1'b1    // waiting out the minimum toggle spacing
   } pace_state_e;

   // Width of the spacing counter: clog2(GAP), never less than one bit.
   function automatic int pacer_gap_width(input int gap);
      return (gap > 1) ? $clog2(gap) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/strobe_pacer_if.sv
`default_nettype none
// ============================================================================
//  Module   : strobe_pacer_if
//  Purpose  : Strobe input / toggle output bundle of the strobe pacer.
//  Revision : 1.0  initial release
// ============================================================================
interface strobe_pacer_if #(
   parameter int CNT_W = 3
);
   logic             din_pulse;   // one strobe per cycle when high
   logic             clr_ovf;     // clears the sticky overflow flag
   logic             dout_togl;   // toggle line towards the crossing
   logic [CNT_W-1:0] pending;     // strobes accepted but not yet emitted
   logic             busy;        // work queued or spacing in progress
   logic             overflow;    // at least one strobe was dropped

   // Strobe source side
   modport master (
      output din_pulse,
      output clr_ovf,
      input  dout_togl,
      input  pending,
      input  busy,
      input  overflow
   );

   // Pacer side
   modport slave (
      input  din_pulse,
      input  clr_ovf,
      output dout_togl,
      output pending,
      output busy,
      output overflow
   );
endinterface
`default_nettype wire

// File: rtl/strobe_pend_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : strobe_pend_ctr
//  Purpose  : Saturating up/down counter of queued strobes. A simultaneous
//             increment and decrement leaves the count unchanged, even at the
//             maximum; an increment alone at the maximum is reported as drop.
//  Revision : 1.0  initial release
// ============================================================================
module strobe_pend_ctr #(
   parameter int CNT_W = 3
) (
   input  wire logic             clk,
   input  wire logic             arst,
   input  wire logic             inc,
   input  wire logic             dec,
   output logic      [CNT_W-1:0] value,
   output logic                  at_max,
   output logic                  drop
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] value_q;
   logic [CNT_W-1:0] value_d;

   assign value  = value_q;
   assign at_max = (value_q == CNT_MAX);
   assign drop   = inc & ~dec & at_max;

   // Next count: saturate on increment, never wrap below zero on decrement.
   always_comb begin
      value_d = value_q;
      if (inc && !dec && !at_max) begin
         value_d = value_q + 1'b1;
      end else if (dec && !inc && (value_q != '0)) begin
         value_d = value_q - 1'b1;
      end
   end

   // Count register, cleared asynchronously.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/strobe_pacer.sv
`default_nettype none
// ============================================================================
//  Module   : strobe_pacer
//  Purpose  : Queues single-cycle strobes and re-emits them as transitions on
//             a toggle line spaced at least GAP cycles apart, so a downstream
//             toggle synchronizer never merges two strobes.
//  Revision : 1.0  initial release
// ============================================================================
module strobe_pacer
   import strobe_pacer_pkg::*;
#(
   parameter int GAP   = 4,
   parameter int CNT_W = 3
) (
   input  wire logic    clk,
   input  wire logic    arst,
   strobe_pacer_if.slave bus
);

   localparam int             GAP_W    = pacer_gap_width(GAP);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);

   logic [GAP_W-1:0] gap_q;
   logic [GAP_W-1:0] gap_d;
   logic             togl_q;
   logic             togl_d;
   logic             ovf_q;
   logic             ovf_d;

   pace_state_e      state;
   logic             fire;
   logic [CNT_W-1:0] cnt_value;
   logic             cnt_at_max;
   logic             cnt_drop;
   logic             unused_at_max;

   // Pending queue: every accepted strobe counts up, every emission counts down.
   strobe_pend_ctr #(
      .CNT_W (CNT_W)
   ) u_pend_ctr (
      .clk    (clk),
      .arst   (arst),
      .inc    (bus.din_pulse),
      .dec    (fire),
      .value  (cnt_value),
      .at_max (cnt_at_max),
      .drop   (cnt_drop)
   );

   // Saturation is already folded into the counter's drop strobe.
   assign unused_at_max = cnt_at_max;

   assign state = (gap_q == '0) ? PACE_READY : PACE_SPACING;
   // A fresh strobe fires straight through when idle, without queueing.
   assign fire  = ((cnt_value != '0) | bus.din_pulse) & (state == PACE_READY);

   // Next-state for spacing counter, toggle line and sticky overflow.
   always_comb begin
      gap_d  = gap_q;
      togl_d = togl_q;
      ovf_d  = ovf_q;
      if (fire) begin
         togl_d = ~togl_q;
         gap_d  = GAP_LOAD;
      end else if (state == PACE_SPACING) begin
         gap_d  = gap_q - 1'b1;
      end
      // A drop in the same cycle as a clear must leave the flag set.
      if (cnt_drop) begin
         ovf_d = 1'b1;
      end else if (bus.clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   // Pacer state registers, cleared asynchronously.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         gap_q  <= '0;
         togl_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         gap_q  <= gap_d;
         togl_q <= togl_d;
         ovf_q  <= ovf_d;
      end
   end

   assign bus.dout_togl = togl_q;
   assign bus.pending   = cnt_value;
   assign bus.overflow  = ovf_q;
   assign bus.busy      = (cnt_value != '0) | (state == PACE_SPACING);

endmodule
`default_nettype wire

// File: tb/tb_strobe_pacer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_strobe_pacer
//  Purpose  : Self-checking bench for strobe_pacer (GAP=4 and GAP=1 builds).
//  Revision : 1.0  initial release
// ============================================================================
module tb_strobe_pacer;

   logic clk = 1'b0;
   logic arst;
   always #5 clk = ~clk;

   strobe_pacer_if #(.CNT_W(3)) b4 ();
   strobe_pacer_if #(.CNT_W(3)) b1 ();

   strobe_pacer #(.GAP(4), .CNT_W(3)) u4 (
      .clk  (clk),
      .arst (arst),
      .bus  (b4.slave)
   );

   strobe_pacer #(.GAP(1), .CNT_W(3)) u1 (
      .clk  (clk),
      .arst (arst),
      .bus  (b1.slave)
   );

   int   n_cmp  = 0;
   int   n_bad  = 0;
   int   edge_n = 0;
   int   base   = 0;
   bit   mask   = 1'b1;
   int   q4 [$];
   int   q1 [$];
   logic p4 = 1'b0;
   logic p1 = 1'b0;
   int   exp_p [0:8];

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Toggle monitor: each transition on a toggle line pops the edge it was
   // expected on and compares against the edge it actually appeared on.
   always @(negedge clk) begin
      if (mask || arst) begin
         p4 = b4.dout_togl;
         p1 = b1.dout_togl;
      end else begin
         if (b4.dout_togl !== p4) begin
            if (q4.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL togl4_unexpected: got toggle at edge %0d expected none", edge_n - base - 1);
            end else begin
               chk("togl4_edge", edge_n - base - 1, q4.pop_front());
            end
            p4 = b4.dout_togl;
         end
         if (b1.dout_togl !== p1) begin
            if (q1.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL togl1_unexpected: got toggle at edge %0d expected none", edge_n - base - 1);
            end else begin
               chk("togl1_edge", edge_n - base - 1, q1.pop_front());
            end
            p1 = b1.dout_togl;
         end
      end
   end

   // One clock edge with the given inputs; returns at the following negedge.
   task automatic cyc(input logic d4, input logic c4, input logic d1);
      b4.din_pulse = d4;
      b4.clr_ovf   = c4;
      b1.din_pulse = d1;
      b1.clr_ovf   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      b4.din_pulse = 1'b0;
      b4.clr_ovf   = 1'b0;
      b1.din_pulse = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 1'b0);
   endtask

   // The next posedge becomes edge 0 of the scenario.
   task automatic start();
      base = edge_n;
   endtask

   initial begin
      b4.din_pulse = 1'b0; b4.clr_ovf = 1'b0;
      b1.din_pulse = 1'b0; b1.clr_ovf = 1'b0;
      arst = 1'b1;
      exp_p = '{0, 1, 2, 2, 1, 1, 1, 1, 0};
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_togl",     b4.dout_togl, 0);
      chk("rst_pending",  b4.pending,   0);
      chk("rst_busy",     b4.busy,      0);
      chk("rst_overflow", b4.overflow,  0);
      arst = 1'b0;
      @(negedge clk);
      mask = 1'b0;

      // Single strobe at edge 10
      start();
      idle(10);
      q4.push_back(10);
      cyc(1'b1, 1'b0, 1'b0);
      chk("single_togl",    b4.dout_togl, 1);
      chk("single_pending", b4.pending,   0);
      chk("single_busy11",  b4.busy,      1);
      cyc(1'b0, 1'b0, 1'b0);
      chk("single_busy12",  b4.busy,      1);
      cyc(1'b0, 1'b0, 1'b0);
      chk("single_busy13",  b4.busy,      1);
      cyc(1'b0, 1'b0, 1'b0);
      chk("single_busy14",  b4.busy,      0);
      idle(6);

      // Burst of three at edges 10..12
      start();
      idle(10);
      q4.push_back(10); q4.push_back(14); q4.push_back(18);
      for (int i = 0; i < 9; i++) begin
         cyc(i < 3, 1'b0, 1'b0);
         chk($sformatf("burst_pending_e%0d", 10 + i), b4.pending, exp_p[i]);
      end
      idle(6);

      // Overflow: strobes on edges 0..11, clear colliding with a drop at 11
      start();
      for (int k = 0; k < 10; k++) q4.push_back(4 * k);
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, i == 11, 1'b0);
         if (i == 9) begin
            chk("ovf_pending_max", b4.pending,  7);
            chk("ovf_flag_e9",     b4.overflow, 0);
         end
         if (i == 10) chk("ovf_flag_e10",  b4.overflow, 1);
         if (i == 11) chk("clr_vs_set",    b4.overflow, 1);
      end
      idle(24);
      chk("ovf_pending_e35", b4.pending, 1);
      cyc(1'b0, 1'b0, 1'b0);
      chk("ovf_pending_e36", b4.pending, 0);
      idle(4);
      chk("ovf_busy_done",   b4.busy,     0);
      chk("ovf_sticky",      b4.overflow, 1);
      cyc(1'b0, 1'b1, 1'b0);
      chk("ovf_cleared",     b4.overflow, 0);
      idle(4);

      // Asynchronous reset with pending=2 and toggle line high
      start();
      q4.push_back(10);
      idle(10);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("pre_rst_togl",    b4.dout_togl, 1);
      chk("pre_rst_pending", b4.pending,   2);
      mask = 1'b1;
      #1 arst = 1'b1;
      #1;
      chk("arst_togl",     b4.dout_togl, 0);
      chk("arst_pending",  b4.pending,   0);
      chk("arst_busy",     b4.busy,      0);
      chk("arst_overflow", b4.overflow,  0);
      @(negedge clk);
      arst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0);
      mask = 1'b0;
      start();
      q4.push_back(2);
      idle(2);
      cyc(1'b1, 1'b0, 1'b0);
      chk("post_rst_togl", b4.dout_togl, 1);
      idle(6);

      // GAP=1 build: five back-to-back strobes
      start();
      for (int k = 0; k < 5; k++) q1.push_back(k);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 1'b0, 1'b1);
         chk($sformatf("gap1_togl_e%0d", i), b1.dout_togl, (i % 2 == 0) ? 1 : 0);
         chk($sformatf("gap1_pending_e%0d", i), b1.pending, 0);
         chk($sformatf("gap1_overflow_e%0d", i), b1.overflow, 0);
      end
      idle(3);
      chk("gap1_busy_done", b1.busy, 0);

      chk("q4_drained", q4.size(), 0);
      chk("q1_drained", q1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
